// File: rtl/ram_stream_reader.sv
// Streams a contiguous run of words out of a registered-read RAM as a valid/ready stream with last marking.
// Optional build macro RAM_STREAM_READER_REVERSE_EN walks the run from its top address down to base_addr.
module ram_stream_reader #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rdaddress,
    input  logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic [ADDR_W-1:0] rdaddress_q, rdaddress_d;
    logic [1:0]        flight_q, flight_d;
    logic [1:0]        tag_q, tag_d;
    logic [WIDTH-1:0]  mem_q [3];
    logic [WIDTH-1:0]  mem_d [3];
    logic              last_q [3];
    logic              last_d [3];
    logic [1:0]        wr_ptr_q, wr_ptr_d;
    logic [1:0]        rd_ptr_q, rd_ptr_d;
    logic [1:0]        occ_q, occ_d;

    logic              push;
    logic              pop;
    logic              issue;
    logic              issue_last;
    logic              issue_ok;
    logic [2:0]        load;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] step_addr;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

`ifdef RAM_STREAM_READER_REVERSE_EN
    assign first_addr = base_addr + num_words[ADDR_W-1:0] - ADDR_ONE;
    assign step_addr  = rdaddress_q - ADDR_ONE;
`else
    assign first_addr = base_addr;
    assign step_addr  = rdaddress_q + ADDR_ONE;
`endif

    // Stream handshake: a beat transfers when m_valid & m_ready; m_valid and m_data hold until then.
    assign m_valid = (occ_q != 2'd0);
    assign pop     = m_valid & m_ready;
    assign push    = flight_q[1];

    // Buffered plus in-flight words may never exceed the three FIFO slots.
    assign load     = {1'b0, occ_q} + {2'b00, flight_q[0]} + {2'b00, flight_q[1]};
    assign issue_ok = (load <= (pop ? 3'd3 : 3'd2));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        issued_d    = issued_q;
        rdaddress_d = rdaddress_q;
        flight_d    = {flight_q[0], 1'b0};
        tag_d       = {tag_q[0], 1'b0};
        mem_d       = mem_q;
        last_d      = last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        issue       = 1'b0;
        issue_last  = 1'b0;
        occ_d       = occ_q + {1'b0, push} - {1'b0, pop};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    count_d = num_words;
                    if (num_words == '0) begin
                        state_d = S_DONE;
                    end else begin
                        // First read goes out in the start cycle so rdaddress is valid one cycle later.
                        issue       = 1'b1;
                        rdaddress_d = first_addr;
                        issued_d    = CNT_ONE;
                        issue_last  = (num_words == CNT_ONE);
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if ((issued_q != count_q) && issue_ok) begin
                    issue       = 1'b1;
                    rdaddress_d = step_addr;
                    issued_d    = issued_q + CNT_ONE;
                    issue_last  = (issued_d == count_q);
                end
                if (issued_d == count_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((occ_d == 2'd0) && !flight_q[0]) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue) begin
            flight_d[0] = 1'b1;
            tag_d[0]    = issue_last;
        end
        if (push) begin
            mem_d[wr_ptr_q]  = q;
            last_d[wr_ptr_q] = tag_q[1];
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            issued_q    <= '0;
            rdaddress_q <= '0;
            flight_q    <= '0;
            tag_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            for (int i = 0; i < 3; i++) begin
                mem_q[i]  <= '0;
                last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            rdaddress_q <= rdaddress_d;
            flight_q    <= flight_d;
            tag_q       <= tag_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            for (int i = 0; i < 3; i++) begin
                mem_q[i]  <= mem_d[i];
                last_q[i] <= last_d[i];
            end
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign rdaddress = rdaddress_q;
    assign m_data    = m_valid ? mem_q[rd_ptr_q] : '0;
    assign m_last    = m_valid & last_q[rd_ptr_q];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader: cycle-exact runs, back-pressure, wrap, reset and ignored restart.
module tb_ram_stream_reader;

    localparam int WIDTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_words;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rdaddress;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    int n_chk = 0;
    int n_err = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] ram [64];

    ram_stream_reader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_words(num_words), .busy(busy), .done(done), .rdaddress(rdaddress),
        .q(q), .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
    );

    // clock / reset, RAM model with one-cycle registered read
    always #5 clk = ~clk;

    always @(posedge clk) q <= ram[rdaddress];

    function automatic logic [WIDTH-1:0] word(input int a);
        logic [31:0] i;
        i = 32'(a & 63);
        return {i ^ 32'hA5A5_A5A5, i};
    endfunction

    function automatic int beat_addr(input int base, input int n, input int j);
`ifdef RAM_STREAM_READER_REVERSE_EN
        return (base + n - 1 - j) & 63;
`else
        return (base + j) & 63;
`endif
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called #1 after a rising edge; start is driven in cycle 0 and every cycle up to n+4 is checked.
    task automatic run_exact(input int base, input int n, input int glitch);
        bit ev;
        base_addr = ADDR_W'(base);
        num_words = (ADDR_W+1)'(n);
        start     = 1'b1;
        m_ready   = 1'b1;
        for (int c = 0; c <= n + 4; c++) begin
            @(negedge clk);
            ev = (n > 0) && (c >= 3) && (c <= n + 2);
            check("valid", m_valid, ev);
            if (ev) check("data", m_data, word(beat_addr(base, n, c - 3)));
            check("last", m_last, ev && (c == n + 2));
            check("done", done, (n == 0) ? (c == 1) : (c == n + 3));
            check("busy", busy, (n == 0) ? (c == 1) : (c >= 1 && c <= n + 3));
            if (c == 1 && n > 0) check("rdaddr", rdaddress, beat_addr(base, n, 0));
            @(posedge clk);
            #1;
            start = (c + 1 == glitch);
            if (start) begin
                base_addr = 6'd40;
                num_words = 7'd3;
            end
        end
        start = 1'b0;
    endtask

    task automatic run_stall(input int base, input int n);
        bit              pat [4];
        bit              prev_stall;
        bit              seen_done;
        logic [WIDTH-1:0] held;
        logic [WIDTH-1:0] e;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_q.delete();
        for (int j = 0; j < n; j++) exp_q.push_back(word(beat_addr(base, n, j)));
        prev_stall = 1'b0;
        seen_done  = 1'b0;
        held       = '0;
        base_addr  = ADDR_W'(base);
        num_words  = (ADDR_W+1)'(n);
        start      = 1'b1;
        m_ready    = pat[0];
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (prev_stall) begin
                check("hold_valid", m_valid, 1'b1);
                check("hold_data", m_data, held);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", m_data, '0);
                end else begin
                    e = exp_q.pop_front();
                    check("stall_data", m_data, e);
                    check("stall_last", m_last, exp_q.size() == 0);
                end
            end
            prev_stall = m_valid && !m_ready;
            held       = m_data;
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            start   = 1'b0;
            m_ready = pat[(k + 1) % 4];
        end
        check("stall_done", seen_done, 1'b1);
        check("stall_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(negedge clk);
        check("stall_idle", busy, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_reset_mid();
        base_addr = 6'd4;
        num_words = 7'd8;
        start     = 1'b1;
        m_ready   = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c >= 3) check("pre_rst_data", m_data, word(4 + c - 3));
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_valid", m_valid, 1'b0);
        check("rst_last", m_last, 1'b0);
        check("rst_done", done, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rst_no_stray", m_valid, 1'b0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = word(i);
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        m_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_valid", m_valid, 1'b0);
        check("reset_last", m_last, 1'b0);
        check("reset_data", m_data, '0);
        check("reset_rdaddr", rdaddress, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_exact(4, 8, 0);
        run_stall(4, 8);
        run_exact(62, 4, 0);
        run_exact(5, 0, 0);
        run_exact(0, 64, 0);
        run_reset_mid();
        run_exact(0, 2, 0);
        run_exact(10, 6, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read sequencer placed directly downstream of a `simple_ram` operand store in the IDDMM datapath. On a `start` command it walks a contiguous run of RAM words, driving the RAM read address and absorbing the RAM's one-cycle registered read latency. It presents the words as a valid/ready stream with `last` marking, and sustains one word per cycle under back-pressure without dropping or duplicating data. It feeds the multiplier word pipeline with operand limbs of a 4096-bit value.

## Interface
Parameters:
- `WIDTH`, 64: word width; must equal the RAM `width`.
- `ADDR_W`, 6: address width; must equal the RAM `widthad`.

Ports:
- `clk` in 1: single clock; RAM shares it.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: command strobe; honoured only in IDLE.
- `base_addr` in ADDR_W: first word address, sampled with `start`.
- `num_words` in ADDR_W+1: word count, sampled with `start`; legal range 0..2^ADDR_W.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse after the last beat is accepted.
- `rdaddress` out ADDR_W: registered; connects to RAM `rdaddress`.
- `q` in WIDTH: RAM read data; valid one cycle after `rdaddress`.
- `m_data` out WIDTH: stream data.
- `m_valid` out 1: stream valid.
- `m_last` out 1: high with the final beat only.
- `m_ready` in 1: stream ready from the consumer.

## Operation
- States:
  - IDLE: `start` latches base and count. If count=0, go to DONE; otherwise go to ISSUE.
  - ISSUE: issue reads. Go to DRAIN once all `num_words` reads are issued.
  - DRAIN: go to DONE when the output buffer is empty and no read is in flight.
  - DONE: `done`=1 for one cycle, then IDLE.
- Read pipeline: an issue decision at cycle t registers `rdaddress` in t+1. `q` is captured into the output buffer at the end of t+2. A 2-bit shift tag tracks in-flight reads.
- Output buffer: 3-entry FIFO holding data and the last flag. `m_data`, `m_valid` and `m_last` come from the FIFO head.
- Issue rule: a read is issued in a cycle only if occupancy + in_flight − pop ≤ 2, where pop = `m_valid & m_ready`. The FIFO therefore never overflows.
- Address arithmetic: modulo 2^ADDR_W. A run crossing the top address wraps to 0.
- Word counter: ADDR_W+1 bits. `num_words` = 2^ADDR_W reads every address exactly once.
- `m_last` is the tag of the read whose issue-count equals `num_words`.
- `start` outside IDLE is ignored; latched parameters do not change.
- `m_valid` never deasserts without a handshake. `m_data` is stable while `m_valid & !m_ready`.
- Reset mid-operation: next cycle state=IDLE, FIFO and in-flight tags cleared, and no stray beats appear.

## Timing
- Reset values: `busy`=0, `done`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `rdaddress`=0.
- Latency: `start` at cycle 0 (count ≥ 1, `m_ready`=1):
  - cycle 1: `rdaddress`=first address.
  - cycle 3: first `m_valid`.
  - Last beat at cycle 2+N.
  - `done` at cycle 3+N, `busy` low at cycle 4+N.
- Throughput: 1 word/cycle while `m_ready`=1.
- Stall: deasserting `m_ready` stops issue within one cycle. At most 3 words buffer, and output resumes on the cycle `m_ready` returns.
- `num_words`=0: `busy` is high in cycle 1, `done` is pulsed in cycle 1, and there are no beats and no reads.

## Configuration
- `RAM_STREAM_READER_REVERSE_EN`:
  - Defined: addresses run from base_addr+num_words−1 down to base_addr (most-significant limb first, modulo wrap). `m_last` marks the `base_addr` word.
  - Undefined: ascending from `base_addr`.
- Interface and timing are identical in both builds.

## Test plan
- RAM preloaded with mem[i]=i. Start base=4, N=8, `m_ready`=1 → beats 4..11 on consecutive cycles 3..10, `m_last` on 11, `done` at cycle 11.
- Same stimulus with `m_ready` toggling 1,0,0,1 repeating → the same 8 words in order, no duplicates, data held during stalls, FIFO occupancy never exceeds 3.
- Base=62, N=4, ADDR_W=6 → beats 62, 63, 0, 1 (REVERSE_EN build: 1, 0, 63, 62).
- N=0 → `done` one cycle after `start`, `m_valid` stays 0. N=64 → all 64 words, then `done`.
- `rst` asserted after 3 beats of an N=8 run → next cycle `busy`=0 and `m_valid`=0. A new start with base=0, N=2 yields exactly mem[0], mem[1].
- `start` pulsed again mid-run with a different base → ignored; the original run completes unchanged.
